// File: rtl/mem_pkg.sv
// mem_pkg: shared request field positions, access lengths
// and FSM state encoding for the memory stage.
package mem_pkg;

  localparam int REQ_EN     = 4;
  localparam int REQ_LEN_HI = 3;
  localparam int REQ_LEN_LO = 2;
  localparam int REQ_WR     = 1;
  localparam int REQ_UNS    = 0;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_X = 2'd2;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD      = 2'd1,
    S_RD_LAST = 2'd2,
    S_WR      = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ext.sv
// mem_ext: sign/zero extension of an assembled load value.
// Ports: rbuf (raw bytes), len, uns -> ext (32-bit result).
module mem_ext
  import mem_pkg::*;
(
  input  logic [31:0] rbuf,
  input  logic [1:0]  len,
  input  logic        uns,
  output logic [31:0] ext
);

  always_comb begin
    ext = rbuf;
    unique case (1'b1)
      (len == LEN_B): ext = {{24{~uns & rbuf[7]}}, rbuf[7:0]};
      (len == LEN_H): ext = {{16{~uns & rbuf[15]}}, rbuf[15:0]};
      default:        ext = rbuf;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory stage over an 8-bit sync RAM.
// Ports: clk, rst (sync, high); req_e/req_addr/req_data,
// wa_i/we_i from execute; ram_din/ram_a/ram_dout/ram_wr to RAM;
// stall_req upstream; wa_o/we_o/wdata_o write-back triple.
// MEM_ALIGN_CHECK_EN adds misalign_o and drops misaligned
// half/word accesses instead of running them.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        req_e,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [4:0]        wa_i,
  input  logic              we_i,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  output logic              stall_req,
  output logic [4:0]        wa_o,
  output logic              we_o,
  output logic [31:0]       wdata_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  state_t            state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic [1:0]        len;
  logic              uns;
  logic              we_l;
  logic [4:0]        wa_l;
  logic [31:0]       rbuf;
  logic [31:0]       rbuf_nx;
  logic [31:0]       ext;

  logic [1:0] req_len;
  logic       legal;
  logic       mis;
  logic       accept;
  logic       last;
  logic [1:0] bi;

  assign req_len = req_e[REQ_LEN_HI:REQ_LEN_LO];
  assign legal   = req_e[REQ_EN] && (req_len != LEN_X);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = legal &&
    (((req_len == LEN_H) && req_addr[0]) ||
     ((req_len == LEN_W) && (req_addr[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign accept = (state == S_IDLE) && legal && !mis;
  assign last   = (cnt == {1'b0, len});

  // read data trails the issued address by the RAM latency
  assign bi = 2'(cnt - 3'(RAM_RD_LAT));

  always_comb begin
    rbuf_nx = rbuf;
    if ((state == S_RD || state == S_RD_LAST) && cnt != 3'd0)
      rbuf_nx[{bi, 3'b000} +: 8] = ram_din;
  end

  mem_ext u_ext (
    .rbuf (rbuf_nx),
    .len  (len),
    .uns  (uns),
    .ext  (ext)
  );

  assign ram_a = (state == S_RD || state == S_WR) ?
                 addr + ADDR_W'(cnt) : '0;
  assign ram_dout = (state == S_WR) ?
                    data[{cnt[1:0], 3'b000} +: 8] : 8'h00;
  // gated by rst so an aborted store stops writing at once
  assign ram_wr = (state == S_WR) && !rst;
  assign stall_req = accept || (state == S_RD) ||
                     ((state == S_WR) && !last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr    <= '0;
      data    <= '0;
      len     <= '0;
      uns     <= 1'b0;
      we_l    <= 1'b0;
      wa_l    <= '0;
      rbuf    <= '0;
      wa_o    <= '0;
      we_o    <= 1'b0;
      wdata_o <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            addr    <= req_addr;
            data    <= req_data;
            len     <= req_len;
            uns     <= req_e[REQ_UNS];
            we_l    <= we_i;
            wa_l    <= wa_i;
            rbuf    <= '0;
            wa_o    <= '0;
            we_o    <= 1'b0;
            wdata_o <= '0;
            state   <= req_e[REQ_WR] ? S_WR : S_RD;
          end else if (mis) begin
            wa_o    <= '0;
            we_o    <= 1'b0;
            wdata_o <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_o <= 1'b1;
`endif
          end else begin
            wa_o    <= wa_i;
            we_o    <= we_i;
            wdata_o <= 32'(req_addr);
          end
        end
        S_RD: begin
          rbuf <= rbuf_nx;
          cnt  <= cnt + 3'd1;
          we_o <= 1'b0;
          if (last) state <= S_RD_LAST;
        end
        S_RD_LAST: begin
          rbuf    <= rbuf_nx;
          wdata_o <= ext;
          wa_o    <= wa_l;
          we_o    <= we_l;
          cnt     <= '0;
          state   <= S_IDLE;
        end
        S_WR: begin
          cnt     <= cnt + 3'd1;
          wdata_o <= '0;
          we_o    <= 1'b0;
          if (last) begin
            wa_o  <= wa_l;
            we_o  <= we_l;
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl loads, stores,
// pass-through, reset abort and address wrap / misalign.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_e;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [4:0]  wa_i;
  logic        we_i;
  logic [7:0]  ram_din;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic        stall_req;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] wdata_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
  logic        m_log [0:15];
`endif

  int total = 0;
  int bad = 0;

  logic [7:0]  mem   [0:4095];
  logic [31:0] a_log [0:15];
  logic        w_log [0:15];
  logic [7:0]  d_log [0:15];

  mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_e     (req_e),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wa_i      (wa_i),
    .we_i      (we_i),
    .ram_din   (ram_din),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .stall_req (stall_req),
    .wa_o      (wa_o),
    .we_o      (we_o),
    .wdata_o   (wdata_o)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // one-cycle read latency RAM, read-only in this bench
  always @(posedge clk) ram_din <= mem[ram_a[11:0]];

  task automatic run(
    input  logic [4:0]  e,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          stalls,
    output int          lat,
    output int          wes,
    output logic [31:0] res,
    output logic [4:0]  rwa
  );
    stalls = 0;
    lat = -1;
    wes = 0;
    res = '0;
    rwa = '0;
    @(posedge clk); #1;
    req_e = e;
    req_addr = a;
    req_data = d;
    wa_i = 5'd9;
    we_i = ~e[1];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      a_log[c] = ram_a;
      w_log[c] = ram_wr;
      d_log[c] = ram_dout;
`ifdef MEM_ALIGN_CHECK_EN
      m_log[c] = misalign_o;
`endif
      if (stall_req) stalls++;
      if (we_o) wes++;
      if (we_o && lat < 0) begin
        lat = c;
        res = wdata_o;
        rwa = wa_o;
      end
      @(posedge clk); #1;
      req_e = '0;
      req_addr = '0;
      req_data = '0;
      we_i = 1'b0;
      wa_i = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_e = '0;
    req_addr = '0;
    req_data = '0;
    wa_i = '0;
    we_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ram_a, ram_dout, ram_wr, stall_req} !== '0) begin
      bad++;
      $display("FAIL reset_ram got=%h/%h/%b/%b want=0",
               ram_a, ram_dout, ram_wr, stall_req);
    end
    total++;
    if ({wa_o, we_o, wdata_o} !== '0) begin
      bad++;
      $display("FAIL reset_wb got=%h/%b/%h want=0",
               wa_o, we_o, wdata_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int s, l, w;
    logic [31:0] r;
    logic [4:0] wa;
    run(5'b11100, 32'h100, 32'h0, s, l, w, r, wa);
    total++;
    if (s !== 5) begin
      bad++;
      $display("FAIL lw_stall got=%0d want=5", s);
    end
    total++;
    if (l !== 6) begin
      bad++;
      $display("FAIL lw_lat got=%0d want=6", l);
    end
    total++;
    if (r !== 32'h44332211) begin
      bad++;
      $display("FAIL lw_data got=%h want=44332211", r);
    end
    total++;
    if (wa !== 5'd9 || w !== 1) begin
      bad++;
      $display("FAIL lw_wb got=wa%0d/n%0d want=wa9/n1", wa, w);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (a_log[i] !== 32'h100 + 32'(i - 1)) begin
        bad++;
        $display("FAIL lw_addr%0d got=%h want=%h",
                 i, a_log[i], 32'h100 + 32'(i - 1));
      end
    end
    total++;
    if (a_log[0] !== 32'h0 || a_log[5] !== 32'h0) begin
      bad++;
      $display("FAIL lw_addr_idle got=%h/%h want=0/0",
               a_log[0], a_log[5]);
    end
  endtask

  task automatic test_ext();
    logic [4:0]  te [5];
    logic [31:0] ta [5];
    logic [31:0] tx [5];
    int          tl [5];
    int s, l, w;
    logic [31:0] r;
    logic [4:0] wa;
    te = '{5'b10000, 5'b10001, 5'b10100, 5'b10101, 5'b10000};
    ta = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h11};
    tx = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
           32'h00008001, 32'h0000007F};
    tl = '{3, 3, 4, 4, 3};
    for (int i = 0; i < 5; i++) begin
      run(te[i], ta[i], 32'h0, s, l, w, r, wa);
      total++;
      if (r !== tx[i] || l !== tl[i]) begin
        bad++;
        $display("FAIL ext%0d got=%h@%0d want=%h@%0d",
                 i, r, l, tx[i], tl[i]);
      end
    end
  endtask

  task automatic test_sh();
    int s, l, w;
    logic [31:0] r;
    logic [4:0] wa;
    run(5'b10110, 32'h200, 32'hDEADBEEF, s, l, w, r, wa);
    total++;
    if (s !== 2) begin
      bad++;
      $display("FAIL sh_stall got=%0d want=2", s);
    end
    total++;
    if (w_log[1] !== 1'b1 || a_log[1] !== 32'h200 ||
        d_log[1] !== 8'hEF) begin
      bad++;
      $display("FAIL sh_b0 got=%b/%h/%h want=1/200/ef",
               w_log[1], a_log[1], d_log[1]);
    end
    total++;
    if (w_log[2] !== 1'b1 || a_log[2] !== 32'h201 ||
        d_log[2] !== 8'hBE) begin
      bad++;
      $display("FAIL sh_b1 got=%b/%h/%h want=1/201/be",
               w_log[2], a_log[2], d_log[2]);
    end
    total++;
    if (w_log[0] !== 1'b0 || w_log[3] !== 1'b0 || w !== 0) begin
      bad++;
      $display("FAIL sh_extra got=%b/%b/%0d want=0/0/0",
               w_log[0], w_log[3], w);
    end
  endtask

  task automatic test_pass();
    @(posedge clk); #1;
    req_e = 5'b00000;
    req_addr = 32'h1234;
    wa_i = 5'd5;
    we_i = 1'b1;
    @(negedge clk);
    total++;
    if (stall_req !== 1'b0) begin
      bad++;
      $display("FAIL pass_stall got=%b want=0", stall_req);
    end
    @(posedge clk); #1;
    req_e = 5'b11000;
    req_addr = 32'h55;
    wa_i = 5'd3;
    @(negedge clk);
    total++;
    if (wa_o !== 5'd5 || we_o !== 1'b1 || wdata_o !== 32'h1234) begin
      bad++;
      $display("FAIL pass_wb got=%0d/%b/%h want=5/1/1234",
               wa_o, we_o, wdata_o);
    end
    total++;
    if (stall_req !== 1'b0 || ram_wr !== 1'b0) begin
      bad++;
      $display("FAIL len2_stall got=%b/%b want=0/0",
               stall_req, ram_wr);
    end
    @(posedge clk); #1;
    req_e = '0;
    req_addr = '0;
    wa_i = '0;
    we_i = 1'b0;
    @(negedge clk);
    total++;
    if (wa_o !== 5'd3 || we_o !== 1'b1 || wdata_o !== 32'h55) begin
      bad++;
      $display("FAIL len2_wb got=%0d/%b/%h want=3/1/55",
               wa_o, we_o, wdata_o);
    end
  endtask

  task automatic test_rst_mid();
    int s, l, w;
    logic [31:0] r;
    logic [4:0] wa;
    @(posedge clk); #1;
    req_e = 5'b11110;
    req_addr = 32'h300;
    req_data = 32'h11223344;
    @(negedge clk);
    @(posedge clk); #1;
    req_e = '0;
    req_addr = '0;
    req_data = '0;
    @(negedge clk);
    total++;
    if (ram_wr !== 1'b1 || ram_a !== 32'h300 || ram_dout !== 8'h44) begin
      bad++;
      $display("FAIL sw_b0 got=%b/%h/%h want=1/300/44",
               ram_wr, ram_a, ram_dout);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (ram_wr !== 1'b1 || ram_a !== 32'h301 || ram_dout !== 8'h33) begin
      bad++;
      $display("FAIL sw_b1 got=%b/%h/%h want=1/301/33",
               ram_wr, ram_a, ram_dout);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ram_wr !== 1'b0) begin
      bad++;
      $display("FAIL sw_abort_wr got=%b want=0", ram_wr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ram_a, ram_wr, stall_req, wa_o, we_o, wdata_o} !== '0) begin
      bad++;
      $display("FAIL sw_after_rst got=%h/%b/%b/%h/%b/%h want=0",
               ram_a, ram_wr, stall_req, wa_o, we_o, wdata_o);
    end
    run(5'b11100, 32'h100, 32'h0, s, l, w, r, wa);
    total++;
    if (r !== 32'h44332211 || l !== 6) begin
      bad++;
      $display("FAIL lw_after_rst got=%h@%0d want=44332211@6", r, l);
    end
  endtask

  task automatic test_wrap();
    int s, l, w;
    logic [31:0] r;
    logic [4:0] wa;
    run(5'b11100, 32'hFFFFFFFE, 32'h0, s, l, w, r, wa);
`ifdef MEM_ALIGN_CHECK_EN
    total++;
    if (m_log[1] !== 1'b1 || m_log[2] !== 1'b0) begin
      bad++;
      $display("FAIL mis_pulse got=%b%b want=10", m_log[1], m_log[2]);
    end
    total++;
    if (s !== 0 || w !== 0 || a_log[1] !== 32'h0 || w_log[1] !== 1'b0) begin
      bad++;
      $display("FAIL mis_drop got=s%0d/we%0d/%h/%b want=s0/we0/0/0",
               s, w, a_log[1], w_log[1]);
    end
`else
    total++;
    if (a_log[1] !== 32'hFFFFFFFE || a_log[2] !== 32'hFFFFFFFF ||
        a_log[3] !== 32'h0 || a_log[4] !== 32'h1) begin
      bad++;
      $display("FAIL wrap_addr got=%h %h %h %h want=fffffffe ffffffff 0 1",
               a_log[1], a_log[2], a_log[3], a_log[4]);
    end
    total++;
    if (r !== 32'hDDCCBBAA || l !== 6) begin
      bad++;
      $display("FAIL wrap_data got=%h@%0d want=ddccbbaa@6", r, l);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'hA5;
    mem[12'h100] = 8'h11;
    mem[12'h101] = 8'h22;
    mem[12'h102] = 8'h33;
    mem[12'h103] = 8'h44;
    mem[12'h010] = 8'h80;
    mem[12'h011] = 8'h7F;
    mem[12'h020] = 8'h01;
    mem[12'h021] = 8'h80;
    mem[12'hFFE] = 8'hAA;
    mem[12'hFFF] = 8'hBB;
    mem[12'h000] = 8'hCC;
    mem[12'h001] = 8'hDD;
    test_reset();
    test_lw();
    test_ext();
    test_sh();
    test_pass();
    test_rst_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
